// File: rtl/change_dispenser.sv
// Pays out a captured change amount as a greedy quarter/dime/nickel sequence over a valid/ready handshake.
// Optional running coin tallies are enabled by defining CHANGE_DISP_TALLY_EN.
module change_dispenser #(
    parameter int WIDTH   = 8,
    parameter int QUARTER = 25,
    parameter int DIME    = 10,
    parameter int NICKEL  = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] balance,
    input  logic             change,
    output logic             coin_valid,
    output logic [2:0]       coin_out,
    input  logic             coin_ready,
    output logic             busy,
    output logic             done,
    output logic             err_rem
`ifdef CHANGE_DISP_TALLY_EN
    ,
    output logic [7:0]       tally_q,
    output logic [7:0]       tally_d,
    output logic [7:0]       tally_n
`endif
);

    localparam logic [WIDTH-1:0] Q_V = WIDTH'(QUARTER);
    localparam logic [WIDTH-1:0] D_V = WIDTH'(DIME);
    localparam logic [WIDTH-1:0] N_V = WIDTH'(NICKEL);

    localparam logic [2:0] COIN_Q = 3'b100;
    localparam logic [2:0] COIN_D = 3'b010;
    localparam logic [2:0] COIN_N = 3'b001;

    typedef enum logic [1:0] {IDLE, PAY, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] rem;
    logic             change_d;
    logic [WIDTH-1:0] coin_val;
    logic [WIDTH-1:0] rem_next;
    logic             accept;

    function automatic logic [2:0] pick(input logic [WIDTH-1:0] amt);
        if (amt >= Q_V)      return COIN_Q;
        else if (amt >= D_V) return COIN_D;
        else if (amt >= N_V) return COIN_N;
        else                 return 3'b000;
    endfunction

    always_comb begin
        coin_val = '0;
        case (coin_out)
            COIN_Q:  coin_val = Q_V;
            COIN_D:  coin_val = D_V;
            COIN_N:  coin_val = N_V;
            default: coin_val = '0;
        endcase
    end

    // rem never underflows: the presented coin was chosen by a >= compare against rem.
    assign rem_next = rem - coin_val;
    assign accept   = coin_valid && coin_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            rem        <= '0;
            change_d   <= 1'b0;
            coin_valid <= 1'b0;
            coin_out   <= 3'b000;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_rem    <= 1'b0;
        end else begin
            change_d <= change;
            case (state)
                IDLE: begin
                    if (change && !change_d) begin
                        rem     <= balance;
                        err_rem <= (balance % N_V) != '0;
                        busy    <= 1'b1;
                        if (balance < N_V) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= PAY;
                            coin_valid <= 1'b1;
                            coin_out   <= pick(balance);
                        end
                    end
                end
                PAY: begin
                    if (accept) begin
                        rem <= rem_next;
                        if (rem_next < N_V) begin
                            state      <= DONE;
                            coin_valid <= 1'b0;
                            coin_out   <= 3'b000;
                            done       <= 1'b1;
                        end else begin
                            coin_out <= pick(rem_next);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CHANGE_DISP_TALLY_EN
    // Lifetime counters: cleared only by reset, saturating rather than wrapping.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tally_q <= '0;
            tally_d <= '0;
            tally_n <= '0;
        end else if (accept) begin
            if (coin_out == COIN_Q && tally_q != 8'hFF) tally_q <= tally_q + 8'd1;
            if (coin_out == COIN_D && tally_d != 8'hFF) tally_d <= tally_d + 8'd1;
            if (coin_out == COIN_N && tally_n != 8'hFF) tally_n <= tally_n + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: queue-based greedy payout model checked every cycle, plus directed literal expectations.
module tb_change_dispenser;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] balance = 8'd0;
    logic       change = 1'b0;
    logic       coin_ready = 1'b0;
    logic       coin_valid;
    logic [2:0] coin_out;
    logic       busy;
    logic       done;
    logic       err_rem;
`ifdef CHANGE_DISP_TALLY_EN
    logic [7:0] tally_q, tally_d, tally_n;
`endif

    change_dispenser #(.WIDTH(8), .QUARTER(25), .DIME(10), .NICKEL(5)) dut (
        .clock(clock), .reset(reset), .balance(balance), .change(change),
        .coin_valid(coin_valid), .coin_out(coin_out), .coin_ready(coin_ready),
        .busy(busy), .done(done), .err_rem(err_rem)
`ifdef CHANGE_DISP_TALLY_EN
        , .tally_q(tally_q), .tally_d(tally_d), .tally_n(tally_n)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a payout is the list of coins the greedy split of the amount produces.
    typedef enum {M_IDLE, M_PAY, M_DONE} mstate_t;
    mstate_t    ms = M_IDLE;
    logic [2:0] mq[$];
    logic       m_chd = 1'b0;
    logic       exp_valid = 1'b0;
    logic [2:0] exp_out = 3'b000;
    logic       exp_busy = 1'b0;
    logic       exp_done = 1'b0;
    logic       exp_err = 1'b0;
    int         tq = 0, td = 0, tn = 0;
    int         amt;

    always @(negedge clock) begin
        chk("coin_valid", coin_valid, exp_valid);
        chk("coin_out", coin_out, exp_out);
        chk("busy", busy, exp_busy);
        chk("done", done, exp_done);
        chk("err_rem", err_rem, exp_err);
`ifdef CHANGE_DISP_TALLY_EN
        chk("tally_q", tally_q, tq);
        chk("tally_d", tally_d, td);
        chk("tally_n", tally_n, tn);
`endif
        // inputs were driven just after the previous posedge and hold until the next one
        if (!reset) begin
            ms = M_IDLE; mq.delete(); m_chd = 1'b0;
            exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
            tq = 0; td = 0; tn = 0;
        end else begin
            case (ms)
                M_IDLE: if (change && !m_chd) begin
                    amt = int'(balance);
                    exp_err = (amt % 5) != 0;
                    repeat (amt / 25) mq.push_back(3'b100);
                    amt = amt % 25;
                    repeat (amt / 10) mq.push_back(3'b010);
                    amt = amt % 10;
                    repeat (amt / 5) mq.push_back(3'b001);
                    exp_busy = 1'b1;
                    exp_done = (mq.size() == 0);
                    ms = (mq.size() == 0) ? M_DONE : M_PAY;
                end
                M_PAY: if (coin_ready) begin
                    if (mq[0] == 3'b100 && tq < 255) tq++;
                    if (mq[0] == 3'b010 && td < 255) td++;
                    if (mq[0] == 3'b001 && tn < 255) tn++;
                    void'(mq.pop_front());
                    if (mq.size() == 0) begin
                        ms = M_DONE;
                        exp_done = 1'b1;
                    end
                end
                M_DONE: begin
                    exp_done = 1'b0;
                    exp_busy = 1'b0;
                    ms = M_IDLE;
                end
                default: ms = M_IDLE;
            endcase
            m_chd = change;
        end
        exp_valid = (ms == M_PAY);
        exp_out   = exp_valid ? mq[0] : 3'b000;
    end

    logic [35:0] seq;
    int ncoin, tdone, nvalid, quiet;

    // Starts a payout in the current cycle (N=0); reports coins accepted, the cycle of done and valid cycles.
    task automatic pay(input logic [7:0] bal, input int stall, input bit toggle, input bit hold,
                       output logic [35:0] s, output int nc, output int td_o, output int nv);
        int t;
        t = 0; s = '0; nc = 0; nv = 0; td_o = -1;
        balance = bal; change = 1'b1; coin_ready = 1'b0;
        while (td_o < 0 && t < 60) begin
            @(posedge clock); #1; t++;
            coin_ready = (t > stall);
            if (toggle) change = (t != 1);
            if (coin_valid) nv++;
            if (coin_valid && coin_ready) begin
                s = {s[32:0], coin_out};
                nc++;
            end
            if (done) td_o = t;
        end
        if (td_o < 0) begin
            n_checks++; n_errors++;
            $display("FAIL pay_timeout: no done within 60 cycles for balance %0d", bal);
        end
        @(posedge clock); #1;
        coin_ready = 1'b0;
        if (!hold) change = 1'b0;
        @(posedge clock); #1;
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;

        // basic payout: 40 -> Q D N
        pay(8'd40, 0, 1'b0, 1'b0, seq, ncoin, tdone, nvalid);
        chk("basic_ncoin", ncoin, 3);
        chk("basic_tdone", tdone, 4);
        chk("basic_seq", seq[8:0], 9'b100_010_001);
        chk("basic_err", err_rem, 0);

        // backpressure: 15 with three stalled cycles
        pay(8'd15, 3, 1'b0, 1'b0, seq, ncoin, tdone, nvalid);
        chk("bp_nvalid", nvalid, 5);
        chk("bp_tdone", tdone, 6);
        chk("bp_seq", seq[5:0], 6'b010_001);

        // zero and sub-nickel amounts
        pay(8'd0, 0, 1'b0, 1'b0, seq, ncoin, tdone, nvalid);
        chk("zero_nvalid", nvalid, 0);
        chk("zero_tdone", tdone, 1);
        chk("zero_err", err_rem, 0);
        pay(8'd3, 0, 1'b0, 1'b0, seq, ncoin, tdone, nvalid);
        chk("sub_nvalid", nvalid, 0);
        chk("sub_tdone", tdone, 1);
        chk("sub_err", err_rem, 1);

        // residue after coins: 29 -> Q, residue 4
        pay(8'd29, 0, 1'b0, 1'b0, seq, ncoin, tdone, nvalid);
        chk("res_ncoin", ncoin, 1);
        chk("res_tdone", tdone, 2);
        chk("res_err", err_rem, 1);

        // edges during PAY and a held level must not recapture
        pay(8'd20, 0, 1'b1, 1'b1, seq, ncoin, tdone, nvalid);
        chk("held_ncoin", ncoin, 2);
        chk("held_seq", seq[5:0], 6'b010_010);
        chk("held_tdone", tdone, 3);
        quiet = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (coin_valid || busy) quiet++;
        end
        chk("held_no_recapture", quiet, 0);
        change = 1'b0;
        @(posedge clock); #1;

        // reset mid-payout after one coin
        balance = 8'd40; change = 1'b1; coin_ready = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        chk("rst_valid", coin_valid, 0);
        chk("rst_out", coin_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b1; change = 1'b0; coin_ready = 1'b0;
        repeat (2) begin @(posedge clock); #1; end
        pay(8'd40, 0, 1'b0, 1'b0, seq, ncoin, tdone, nvalid);
        chk("post_rst_ncoin", ncoin, 3);
        chk("post_rst_tdone", tdone, 4);

        // maximum amount then a second payout back to back
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        pay(8'd255, 0, 1'b0, 1'b0, seq, ncoin, tdone, nvalid);
        chk("max_ncoin", ncoin, 11);
        chk("max_tdone", tdone, 12);
        chk("max_last", seq[2:0], 3'b001);
        chk("max_err", err_rem, 0);
        pay(8'd35, 0, 1'b0, 1'b0, seq, ncoin, tdone, nvalid);
        chk("p35_seq", seq[5:0], 6'b100_010);
        chk("p35_tdone", tdone, 3);
        chk("p35_err", err_rem, 0);
`ifdef CHANGE_DISP_TALLY_EN
        chk("tally_q_lit", tally_q, 11);
        chk("tally_d_lit", tally_d, 1);
        chk("tally_n_lit", tally_n, 1);
`endif

        // ready asserted while idle has no effect
        coin_ready = 1'b1;
        repeat (3) begin @(posedge clock); #1; end
        chk("idle_ready_valid", coin_valid, 0);
        coin_ready = 1'b0;
        @(posedge clock); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
